// File: rtl/sap_fetch_unit.sv
// sap_fetch_unit: PC, MAR, IR and flag registers for the SAP datapath.
// Latency: register loads land on the rising clk edge; bus drive is combinational.
// Backpressure: none; every control state is captured on exactly one rising edge.
//
// Ports:
//   clk, rst          - clock, asynchronous active-low reset
//   ControlSignal     - 18-bit control word; bits 0..6 used here
//   bus_in            - shared bus value (OR of all drivers)
//   alu_zero/carry    - ALU status captured by FLAG_LOAD
//   opcode            - IR upper field to the control unit
//   flagReg           - {zero, carry}
//   mem_addr          - MAR contents to RAM
//   bus_out, bus_oe   - this block's bus drive
//   pc                - current program counter
//   bus_err           - sticky PC_OUT/IR_OUT contention flag
module sap_fetch_unit #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [17:0]              ControlSignal,
  input  logic [DATA_W-1:0]        bus_in,
  input  logic                     alu_zero,
  input  logic                     alu_carry,
  output logic [DATA_W-ADDR_W-1:0] opcode,
  output logic [1:0]               flagReg,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        bus_out,
  output logic                     bus_oe,
  output logic [ADDR_W-1:0]        pc,
  output logic                     bus_err
);

  localparam int PAD_W = DATA_W - ADDR_W;

  logic pc_inc, pc_out, pc_load, mar_load, ir_load, ir_out, flag_load;
  logic contention;

  assign pc_inc    = ControlSignal[0];
  assign pc_out    = ControlSignal[1];
  assign pc_load   = ControlSignal[2];
  assign mar_load  = ControlSignal[3];
  assign ir_load   = ControlSignal[4];
  assign ir_out    = ControlSignal[5];
  assign flag_load = ControlSignal[6];

  // Bits 7..17 belong to other datapath blocks.
  logic ctrl_unused;
  assign ctrl_unused = ^ControlSignal[17:7];

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] mar_q;
  logic [DATA_W-1:0] ir_q;
  logic [1:0]        flag_q;
  logic              bus_err_q;

  assign contention = pc_out & ir_out;

  // Two simultaneous drivers would corrupt the bus, so drive nothing and
  // let bus_err record the event instead.
  always_comb begin
    bus_out = '0;
    bus_oe  = 1'b0;
    if (pc_out && !ir_out) begin
      bus_out = {{PAD_W{1'b0}}, pc_q};
      bus_oe  = 1'b1;
    end else if (ir_out && !pc_out) begin
      bus_out = {{PAD_W{1'b0}}, ir_q[ADDR_W-1:0]};
      bus_oe  = 1'b1;
    end
  end

  // All loads sample pre-edge values, so fetch-1 (PC_OUT+MAR_LOAD+PC_INC)
  // puts the old PC in MAR while PC advances.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q      <= '0;
      mar_q     <= '0;
      ir_q      <= '0;
      flag_q    <= '0;
      bus_err_q <= 1'b0;
    end else begin
      if (pc_load)
        pc_q <= bus_in[ADDR_W-1:0];
      else if (pc_inc)
        pc_q <= pc_q + 1'b1;
      if (mar_load)
        mar_q <= bus_in[ADDR_W-1:0];
      if (ir_load)
        ir_q <= bus_in;
      if (flag_load)
        flag_q <= {alu_zero, alu_carry};
      if (contention)
        bus_err_q <= 1'b1;
    end
  end

  assign opcode   = ir_q[DATA_W-1:ADDR_W];
  assign flagReg  = flag_q;
  assign mem_addr = mar_q;
  assign pc       = pc_q;
  assign bus_err  = bus_err_q;

endmodule

// File: tb/tb_sap_fetch_unit.sv
// Directed bench for sap_fetch_unit: reset, fetch, jump, wrap/priority,
// flags, contention and all-bits-set, with hand-computed expectations.
module tb_sap_fetch_unit;

  logic        clk;
  logic        rst;
  logic [17:0] ControlSignal;
  logic [7:0]  bus_in;
  logic [7:0]  ram_drv;
  logic        alu_zero;
  logic        alu_carry;
  logic [3:0]  opcode;
  logic [1:0]  flagReg;
  logic [3:0]  mem_addr;
  logic [7:0]  bus_out;
  logic        bus_oe;
  logic [3:0]  pc;
  logic        bus_err;

  int checks = 0;
  int errors = 0;

  // Shared bus: OR of the other drivers and this block.
  assign bus_in = ram_drv | bus_out;

  sap_fetch_unit #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .ControlSignal (ControlSignal),
    .bus_in        (bus_in),
    .alu_zero      (alu_zero),
    .alu_carry     (alu_carry),
    .opcode        (opcode),
    .flagReg       (flagReg),
    .mem_addr      (mem_addr),
    .bus_out       (bus_out),
    .bus_oe        (bus_oe),
    .pc            (pc),
    .bus_err       (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [17:0] C_PC_INC  = 18'h00001;
  localparam logic [17:0] C_PC_OUT  = 18'h00002;
  localparam logic [17:0] C_PC_LOAD = 18'h00004;
  localparam logic [17:0] C_MAR_LD  = 18'h00008;
  localparam logic [17:0] C_IR_LOAD = 18'h00010;
  localparam logic [17:0] C_IR_OUT  = 18'h00020;
  localparam logic [17:0] C_FLAG_LD = 18'h00040;

  initial begin
    rst = 1'b0;
    ControlSignal = '0;
    ram_drv = '0;
    alu_zero = 1'b0;
    alu_carry = 1'b0;
    tick();
    tick();
    #2 rst = 1'b1;

    // Garbage: loads everything, upper bits set, no bus-out bits.
    ControlSignal = 18'h3FFDD;
    ram_drv = 8'hC9;
    alu_zero = 1'b1;
    alu_carry = 1'b1;
    tick();
    chk("garbage_pc", pc, 4'h9);
    chk("garbage_flags", flagReg, 2'b11);

    // Asynchronous reset between edges.
    #2 rst = 1'b0;
    #1;
    chk("rst_pc", pc, 4'h0);
    chk("rst_mar", mem_addr, 4'h0);
    chk("rst_opcode", opcode, 4'h0);
    chk("rst_flags", flagReg, 2'b00);
    chk("rst_bus_err", bus_err, 1'b0);
    chk("rst_bus_oe", bus_oe, 1'b0);
    chk("rst_bus_out", bus_out, 8'h00);
    tick();
    chk("rst_hold_pc", pc, 4'h0);
    ControlSignal = '0;
    ram_drv = '0;
    alu_zero = 1'b0;
    alu_carry = 1'b0;
    #2 rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_pc", pc, 4'h0);
      chk("idle_state", {opcode, flagReg, mem_addr, bus_err}, 11'h000);
    end

    // Fetch from PC=3.
    ControlSignal = C_PC_LOAD;
    ram_drv = 8'h03;
    tick();
    chk("pc_load3", pc, 4'h3);
    ControlSignal = C_PC_OUT | C_MAR_LD | C_PC_INC;
    ram_drv = 8'h00;
    #1;
    chk("f1_bus_out", bus_out, 8'h03);
    chk("f1_bus_oe", bus_oe, 1'b1);
    tick();
    chk("f1_mar", mem_addr, 4'h3);
    chk("f1_pc", pc, 4'h4);
    ControlSignal = C_IR_LOAD;
    ram_drv = 8'h2A;
    tick();
    chk("f2_opcode", opcode, 4'h2);
    ControlSignal = C_IR_OUT;
    ram_drv = 8'h00;
    #1;
    chk("f2_operand", bus_out, 8'h0A);
    chk("f2_oe", bus_oe, 1'b1);

    // Jump with IR=87.
    ControlSignal = C_IR_LOAD;
    ram_drv = 8'h87;
    tick();
    chk("jmp_opcode", opcode, 4'h8);
    ControlSignal = C_IR_OUT | C_PC_LOAD;
    ram_drv = 8'h00;
    #1;
    chk("jmp_bus_out", bus_out, 8'h07);
    chk("jmp_bus_oe", bus_oe, 1'b1);
    tick();
    chk("jmp_pc", pc, 4'h7);

    // Wrap and priority.
    ControlSignal = C_PC_LOAD;
    ram_drv = 8'h0F;
    tick();
    chk("pc_load15", pc, 4'hF);
    ControlSignal = C_PC_INC;
    ram_drv = 8'h00;
    tick();
    chk("pc_wrap", pc, 4'h0);
    ControlSignal = C_PC_LOAD | C_PC_INC;
    ram_drv = 8'hF5;
    tick();
    chk("pc_prio", pc, 4'h5);
    ControlSignal = C_PC_INC;
    ram_drv = 8'h00;
    tick();
    chk("pc_inc6", pc, 4'h6);
    ControlSignal = '0;
    tick();
    chk("pc_hold", pc, 4'h6);
    chk("mar_hold", mem_addr, 4'h3);

    // Flags.
    ControlSignal = C_FLAG_LD;
    alu_zero = 1'b1;
    alu_carry = 1'b0;
    tick();
    chk("flag_10", flagReg, 2'b10);
    alu_carry = 1'b1;
    tick();
    chk("flag_11", flagReg, 2'b11);
    ControlSignal = '0;
    alu_zero = 1'b0;
    alu_carry = 1'b0;
    tick();
    chk("flag_hold_a", flagReg, 2'b11);
    alu_carry = 1'b1;
    tick();
    chk("flag_hold_b", flagReg, 2'b11);
    ControlSignal = C_FLAG_LD;
    tick();
    chk("flag_01", flagReg, 2'b01);

    // Contention.
    ControlSignal = C_PC_OUT | C_IR_OUT;
    #1;
    chk("cont_oe", bus_oe, 1'b0);
    chk("cont_bus_out", bus_out, 8'h00);
    chk("cont_err_pre", bus_err, 1'b0);
    tick();
    chk("cont_err_set", bus_err, 1'b1);
    ControlSignal = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("cont_err_sticky", bus_err, 1'b1);
    end
    #2 rst = 1'b0;
    #1;
    chk("cont_err_clr", bus_err, 1'b0);
    #2 rst = 1'b1;

    // Every control bit at once from reset state.
    ControlSignal = 18'h0007F;
    ram_drv = 8'h3C;
    alu_zero = 1'b0;
    alu_carry = 1'b1;
    #1;
    chk("all_oe", bus_oe, 1'b0);
    tick();
    chk("all_pc", pc, 4'hC);
    chk("all_mar", mem_addr, 4'hC);
    chk("all_opcode", opcode, 4'h3);
    chk("all_flags", flagReg, 2'b01);
    chk("all_err", bus_err, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
